// File: rtl/dcm_mode_sequencer_pkg.sv
// Shared definitions for the DCM mode sequencer: state codes, relock counter
// sizing and the timer width rule.
package dcm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEASURE   = 3'd1,
        ST_DCM_RST   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    localparam int RELOCK_W = 8;
    localparam logic [RELOCK_W-1:0] RELOCK_SAT = 8'd255;

    // A counter that must reach n needs one bit of headroom above $clog2(n).
    function automatic int tmr_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/dcm_mode_sequencer_if.sv
// Counter-result inputs and DCM control/status outputs of the sequencer,
// grouped so the sequencer and its environment connect through one port.
interface dcm_mode_sequencer_if;
    import dcm_seq_pkg::*;

    logic [31:0]         I_freq_word;
    logic                I_freq_mode;
    logic                I_freq_or;
    logic                I_freq_set;
    logic                I_dcm_locked;
    logic                O_freq_reset;
    logic                O_dcm_reset;
    logic                O_dcm_hf_sel;
    logic                O_ready;
    logic                O_fault;
    logic [2:0]          O_state;
    logic [RELOCK_W-1:0] O_relock_count;

    modport master (
        input  I_freq_word, I_freq_mode, I_freq_or, I_freq_set, I_dcm_locked,
        output O_freq_reset, O_dcm_reset, O_dcm_hf_sel, O_ready, O_fault,
               O_state, O_relock_count
    );

    modport slave (
        output I_freq_word, I_freq_mode, I_freq_or, I_freq_set, I_dcm_locked,
        input  O_freq_reset, O_dcm_reset, O_dcm_hf_sel, O_ready, O_fault,
               O_state, O_relock_count
    );

endinterface

// File: rtl/dcm_mode_sequencer_seq_timer.sv
// Clearable up-counter with a terminal-count flag against a supplied value.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/dcm_mode_sequencer.sv
// Sequences the DCM through measure / configure / reset / wait-lock / run from
// the frequency counter's results, with bounded lock retries and a fault holdoff.
module dcm_mode_sequencer
    import dcm_seq_pkg::*;
#(
    parameter int RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT    = 1000000,
    parameter int MAX_RETRIES     = 3,
    parameter int MISMATCH_CYCLES = 1024,
    parameter int FAULT_HOLDOFF   = 100000
) (
    input  logic                  I_ref_clk,
    input  logic                  I_reset,
    dcm_mode_sequencer_if.master  bus
);

    localparam int W_RST  = tmr_w(RST_CYCLES);
    localparam int W_LOCK = tmr_w(LOCK_TIMEOUT);
    localparam int W_HOLD = tmr_w(FAULT_HOLDOFF);
    localparam int W_TA   = (W_RST > W_LOCK) ? W_RST : W_LOCK;
    localparam int TW     = (W_TA > W_HOLD) ? W_TA : W_HOLD;
    localparam int MW     = tmr_w(MISMATCH_CYCLES);
    localparam int RW     = tmr_w(MAX_RETRIES);

    localparam logic [TW-1:0] RST_TC   = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_TC  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_TC  = TW'(FAULT_HOLDOFF - 1);
    localparam logic [MW-1:0] MM_TC    = MW'(MISMATCH_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);

    seq_state_e          state, state_nx;
    logic [RW-1:0]       retry, retry_nx;
    logic                freq_reset, freq_reset_d;
    logic                dcm_reset, dcm_reset_d;
    logic                hf_sel, hf_sel_d;
    logic                ready, ready_d;
    logic                fault, fault_d;
    logic [RELOCK_W-1:0] relock, relock_d;

    logic          tmr_en, tmr_tc;
    logic [TW-1:0] tmr_tc_val;
    logic          mm_cycle, mm_tc, mm_exit;

    // One interval timer serves every timed state; it restarts on each state change.
    always_comb begin
        tmr_tc_val = HOLD_TC;
        case (state)
            ST_DCM_RST:   tmr_tc_val = RST_TC;
            ST_WAIT_LOCK: tmr_tc_val = LOCK_TC;
            default:      tmr_tc_val = HOLD_TC;
        endcase
    end

    assign tmr_en = (state == ST_DCM_RST) || (state == ST_WAIT_LOCK) || (state == ST_FAULT);

    seq_timer #(.W(TW)) u_interval (
        .clk    (I_ref_clk),
        .rst    (I_reset),
        .clr    (state_nx != state),
        .en     (tmr_en),
        .tc_val (tmr_tc_val),
        .tc     (tmr_tc)
    );

    assign mm_cycle = (state == ST_RUN) && bus.I_freq_set &&
                      (bus.I_freq_or || (bus.I_freq_mode != hf_sel));

    // Any non-mismatch cycle, including leaving RUN, restarts the consecutive count.
    seq_timer #(.W(MW)) u_mismatch (
        .clk    (I_ref_clk),
        .rst    (I_reset),
        .clr    (!mm_cycle),
        .en     (mm_cycle),
        .tc_val (MM_TC),
        .tc     (mm_tc)
    );

    assign mm_exit = mm_cycle && mm_tc;

    // State register with registered outputs
    always_ff @(posedge I_ref_clk) begin
        if (I_reset) begin
            state      <= ST_IDLE;
            retry      <= '0;
            freq_reset <= 1'b1;
            dcm_reset  <= 1'b1;
            hf_sel     <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
            relock     <= '0;
        end else begin
            state      <= state_nx;
            retry      <= retry_nx;
            freq_reset <= freq_reset_d;
            dcm_reset  <= dcm_reset_d;
            hf_sel     <= hf_sel_d;
            ready      <= ready_d;
            fault      <= fault_d;
            relock     <= relock_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        retry_nx = retry;
        case (state)
            ST_IDLE: state_nx = ST_MEASURE;
            ST_MEASURE: begin
                if (bus.I_freq_set) begin
                    state_nx = bus.I_freq_or ? ST_FAULT : ST_DCM_RST;
                end
            end
            ST_DCM_RST: begin
                if (tmr_tc) begin
                    state_nx = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (bus.I_dcm_locked) begin
                    state_nx = ST_RUN;
                    retry_nx = '0;
                end else if (tmr_tc) begin
                    retry_nx = retry + 1'b1;
                    state_nx = (retry_nx < RETRY_LIM) ? ST_DCM_RST : ST_FAULT;
                end
            end
            ST_RUN: begin
                // Losing lock outranks a mode mismatch completing on the same cycle.
                if (!bus.I_dcm_locked) begin
                    state_nx = ST_DCM_RST;
                end else if (mm_exit) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (tmr_tc) begin
                    state_nx = ST_IDLE;
                    retry_nx = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output logic: values for the state being entered
    always_comb begin
        freq_reset_d = 1'b0;
        dcm_reset_d  = 1'b1;
        hf_sel_d     = hf_sel;
        ready_d      = 1'b0;
        fault_d      = fault;
        relock_d     = relock;
        case (state_nx)
            ST_IDLE:      freq_reset_d = 1'b1;
            ST_WAIT_LOCK: dcm_reset_d  = 1'b0;
            ST_RUN: begin
                dcm_reset_d = 1'b0;
                ready_d     = 1'b1;
                fault_d     = 1'b0;
            end
            ST_FAULT:     fault_d = 1'b1;
            default:      ;
        endcase
        if ((state == ST_MEASURE) && bus.I_freq_set && !bus.I_freq_or) begin
            hf_sel_d = bus.I_freq_mode;
        end
        if ((state == ST_RUN) && (state_nx != ST_RUN) && (relock != RELOCK_SAT)) begin
            relock_d = relock + 1'b1;
        end
    end

    assign bus.O_state        = state;
    assign bus.O_freq_reset   = freq_reset;
    assign bus.O_dcm_reset    = dcm_reset;
    assign bus.O_dcm_hf_sel   = hf_sel;
    assign bus.O_ready        = ready;
    assign bus.O_fault        = fault;
    assign bus.O_relock_count = relock;

endmodule

// File: tb/tb_dcm_mode_sequencer.sv
// Scenario bench for dcm_mode_sequencer: expected observations are queued as
// stimulus is applied and compared when the sequencer reaches that point.
module tb_dcm_mode_sequencer;

    typedef struct packed {
        logic [2:0] st;
        logic       frst;
        logic       drst;
        logic       hf;
        logic       rdy;
        logic       flt;
        logic [7:0] rc;
    } obs_t;

    typedef struct {
        logic [2:0] st;
        int         len;
    } run_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];
    run_t run_q[$];

    dcm_mode_sequencer_if bus();

    dcm_mode_sequencer #(
        .RST_CYCLES      (4),
        .LOCK_TIMEOUT    (20),
        .MAX_RETRIES     (2),
        .MISMATCH_CYCLES (8),
        .FAULT_HOLDOFF   (10)
    ) dut (
        .I_ref_clk (clk),
        .I_reset   (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return obs_t'({bus.O_state, bus.O_freq_reset, bus.O_dcm_reset, bus.O_dcm_hf_sel,
                       bus.O_ready, bus.O_fault, bus.O_relock_count});
    endfunction

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.O_state === st) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reset, measure with the given mode, lock as soon as WAIT_LOCK is seen.
    task automatic bring_up(input logic mode, output bit ok);
        bit w;
        bus.I_freq_mode  = mode;
        bus.I_freq_or    = 1'b0;
        bus.I_freq_set   = 1'b1;
        bus.I_dcm_locked = 1'b0;
        bus.I_freq_word  = bus.I_freq_word + 32'd1000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_state(3'd3, 40, w);
        if (w) begin
            bus.I_dcm_locked = 1'b1;
            @(negedge clk);
        end
        ok = w && (bus.O_state === 3'd4);
    endtask

    task automatic test_reset();
        obs_t o, e;
        bus.I_freq_word  = 32'd0;
        bus.I_freq_mode  = 1'b0;
        bus.I_freq_or    = 1'b0;
        bus.I_freq_set   = 1'b0;
        bus.I_dcm_locked = 1'b0;
        rst = 1'b1;
        exp_q.push_back(obs_t'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        repeat (2) @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_state: got %p required %p", o, e);
        end
    endtask

    task automatic test_nominal_low();
        bit ok;
        int n;
        obs_t o, e;
        bus.I_freq_set  = 1'b1;
        bus.I_freq_mode = 1'b0;
        bus.I_freq_word = bus.I_freq_word + 32'd1000;
        rst = 1'b0;
        wait_state(3'd2, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL low_reach_dcm_rst: got state %0d required 2", bus.O_state);
        end
        n = 0;
        while (bus.O_state === 3'd2 && bus.O_dcm_reset === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL low_dcm_reset_len: got %0d cycles required 4", n);
        end
        exp_q.push_back(obs_t'({3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL low_wait_lock: got %p required %p", o, e);
        end
        repeat (5) @(negedge clk);
        bus.I_dcm_locked = 1'b1;
        exp_q.push_back(obs_t'({3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}));
        @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL low_run: got %p required %p", o, e);
        end
    endtask

    task automatic test_high_band_mode_change();
        bit ok;
        obs_t o, e;
        bring_up(1'b1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL high_bring_up: got state %0d required 4", bus.O_state);
        end
        exp_q.push_back(obs_t'({3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}));
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL high_run: got %p required %p", o, e);
        end
        // Seven mismatches broken by one good cycle must not exit.
        for (int i = 0; i < 8; i++) begin
            bus.I_freq_mode = (i == 7);
            @(negedge clk);
            checks++;
            if (bus.O_state !== 3'd4) begin
                failures++;
                $display("FAIL high_stay_run[%0d]: got state %0d required 4", i, bus.O_state);
            end
        end
        bus.I_freq_mode = 1'b0;
        exp_q.push_back(obs_t'({3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}));
        repeat (8) @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL high_mismatch_exit: got %p required %p", o, e);
        end
        exp_q.push_back(obs_t'({3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}));
        wait_state(3'd2, 10, ok);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (!ok || o !== e) begin
            failures++;
            $display("FAIL high_remeasure: got %p required %p", o, e);
        end
    endtask

    task automatic test_lock_timeout();
        bit ok;
        int n;
        int idx;
        run_t r;
        obs_t o, e;
        bus.I_dcm_locked = 1'b0;
        bus.I_freq_mode  = 1'b0;
        bus.I_freq_or    = 1'b0;
        bus.I_freq_set   = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_q.push_back('{st: 3'd2, len: 4});
        run_q.push_back('{st: 3'd3, len: 20});
        run_q.push_back('{st: 3'd2, len: 4});
        run_q.push_back('{st: 3'd3, len: 20});
        run_q.push_back('{st: 3'd5, len: 10});
        exp_q.push_back(obs_t'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}));
        wait_state(3'd2, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_reach_dcm_rst: got state %0d required 2", bus.O_state);
        end
        idx = 0;
        while (run_q.size() > 0) begin
            r = run_q.pop_front();
            n = 0;
            while (bus.O_state === r.st && n < 100) begin
                n++;
                @(negedge clk);
            end
            checks++;
            if (n !== r.len) begin
                failures++;
                $display("FAIL timeout_run[%0d]: state %0d lasted %0d cycles required %0d",
                         idx, r.st, n, r.len);
            end
            idx++;
        end
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL timeout_fault_to_idle: got %p required %p", o, e);
        end
        wait_state(3'd3, 20, ok);
        checks++;
        if (!ok || bus.O_fault !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fault_sticky: got state %0d fault %b required 3/1",
                     bus.O_state, bus.O_fault);
        end
        bus.I_dcm_locked = 1'b1;
        exp_q.push_back(obs_t'({3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}));
        @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL timeout_fault_clear_on_run: got %p required %p", o, e);
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        obs_t o, e;
        bring_up(1'b1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL oor_bring_up: got state %0d required 4", bus.O_state);
        end
        bus.I_freq_or   = 1'b1;
        bus.I_freq_word = bus.I_freq_word + 32'd1000;
        exp_q.push_back(obs_t'({3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1}));
        wait_state(3'd1, 30, ok);
        @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (!ok || o !== e) begin
            failures++;
            $display("FAIL oor_fault: got %p required %p", o, e);
        end
        bus.I_freq_or = 1'b0;
    endtask

    task automatic test_simultaneous_events();
        bit ok;
        obs_t o, e;
        bring_up(1'b0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL simul_bring_up: got state %0d required 4", bus.O_state);
        end
        bus.I_freq_mode = 1'b1;
        repeat (7) @(negedge clk);
        checks++;
        if (bus.O_state !== 3'd4) begin
            failures++;
            $display("FAIL simul_pre_exit: got state %0d required 4", bus.O_state);
        end
        bus.I_dcm_locked = 1'b0;
        exp_q.push_back(obs_t'({3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}));
        exp_q.push_back(obs_t'({3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}));
        @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL simul_lock_loss_priority: got %p required %p", o, e);
        end
        bus.I_freq_mode = 1'b0;
        @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL simul_relock_once: got %p required %p", o, e);
        end
        wait_state(3'd3, 20, ok);
        repeat (19) @(negedge clk);
        checks++;
        if (!ok || bus.O_state !== 3'd3) begin
            failures++;
            $display("FAIL simul_last_wait_cycle: got state %0d required 3", bus.O_state);
        end
        bus.I_dcm_locked = 1'b1;
        exp_q.push_back(obs_t'({3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}));
        @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL simul_lock_beats_timeout: got %p required %p", o, e);
        end
    endtask

    task automatic test_reset_mid_operation();
        bit ok;
        obs_t o, e;
        bus.I_dcm_locked = 1'b0;
        wait_state(3'd3, 20, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || bus.O_state !== 3'd3 || bus.O_relock_count !== 8'd2) begin
            failures++;
            $display("FAIL midreset_setup: got state %0d relock %0d required 3/2",
                     bus.O_state, bus.O_relock_count);
        end
        rst = 1'b1;
        exp_q.push_back(obs_t'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        @(negedge clk);
        o = sample();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL midreset_values: got %p required %p", o, e);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal_low();
        test_high_band_mode_change();
        test_lock_timeout();
        test_out_of_range();
        test_simultaneous_events();
        test_reset_mid_operation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcm_mode_sequencer.md
Name: dcm_mode_sequencer

Overview:
Controller that sequences the DCM from the frequency counter's mode and range results, so the DCM is always configured for the measured input band.
- Sits in the I_ref_clk domain next to dcm_freq_counter and consumes its registered outputs.
- Drives the counter reset, the DCM reset and the DCM low/high-frequency select.
- Runs a measure → configure → reset → wait-lock → run cycle, with bounded retries and fault reporting.

Parameters:
RST_CYCLES, 16, cycles O_dcm_reset is held high per DCM reset pulse (≥1)
LOCK_TIMEOUT, 1000000, cycles allowed in WAIT_LOCK for I_dcm_locked (≥2)
MAX_RETRIES, 3, lock attempts before FAULT (≥1)
MISMATCH_CYCLES, 1024, consecutive mismatch cycles in RUN before re-measure (≥1)
FAULT_HOLDOFF, 100000, cycles spent in FAULT before restart (≥1)

Ports:
I_ref_clk  in  1  sole clock, reference clock domain
I_reset  in  1  synchronous, active-high reset
I_freq_word  in  32  measured frequency word (status only, not used for decisions)
I_freq_mode  in  1  counter mode result (0 = low, 1 = high)
I_freq_or  in  1  counter out-of-range flag
I_freq_set  in  1  counter measurement valid (level)
I_dcm_locked  in  1  DCM lock indicator (already synchronised to I_ref_clk)
O_freq_reset  out  1  frequency counter reset
O_dcm_reset  out  1  DCM reset
O_dcm_hf_sel  out  1  DCM frequency-mode select
O_ready  out  1  DCM locked and configured
O_fault  out  1  sticky fault flag
O_state  out  3  current state encoding
O_relock_count  out  8  saturating count of RUN exits

Behaviour:
- Clocking and reset: one clock, I_ref_clk. Reset is synchronous and active-high (I_reset). All outputs are registered.
- Reset values:
  - state = IDLE; O_freq_reset = 1; O_dcm_reset = 1.
  - O_dcm_hf_sel = 0; O_ready = 0; O_fault = 0; O_relock_count = 0.
  - Timer and retry counters = 0.
  - Reset asserted mid-operation aborts any state with the same values.
- State encoding: IDLE=0, MEASURE=1, DCM_RST=2, WAIT_LOCK=3, RUN=4, FAULT=5. Codes 6 and 7 go to IDLE on the next cycle.
- IDLE:
  - O_freq_reset = 1 and O_dcm_reset = 1 for exactly one cycle.
  - Next state: MEASURE.
- MEASURE:
  - O_freq_reset = 0; O_dcm_reset = 1.
  - Wait for I_freq_set = 1.
  - On that cycle: if I_freq_or = 1, go to FAULT. Otherwise latch O_dcm_hf_sel <= I_freq_mode and go to DCM_RST.
- DCM_RST:
  - O_dcm_reset = 1 for exactly RST_CYCLES cycles; O_dcm_hf_sel is held stable.
  - Then go to WAIT_LOCK.
- WAIT_LOCK:
  - O_dcm_reset = 0; the timer counts from 0.
  - I_dcm_locked = 1: go to RUN, with O_ready = 1 from the first RUN cycle, and clear the retry counter.
  - Timer reaches LOCK_TIMEOUT-1 with no lock: increment the retry counter. If retry < MAX_RETRIES, go to DCM_RST; otherwise go to FAULT.
  - Lock on the timeout cycle: lock wins.
- RUN:
  - O_ready = 1.
  - A mismatch cycle is one where I_freq_set = 1 and (I_freq_or = 1 or I_freq_mode ≠ O_dcm_hf_sel).
  - The mismatch counter increments on each mismatch cycle and clears on any other cycle.
  - Counter reaching MISMATCH_CYCLES: go to IDLE (re-measure).
  - I_dcm_locked = 0: go to DCM_RST on the next cycle. This takes priority over mismatch.
  - On either exit: O_ready = 0 in the next state, and O_relock_count increments, saturating at 255.
  - The mode transition band is handled upstream (hysteresis), so no extra filtering is applied here.
- FAULT:
  - O_fault is set on entry; O_dcm_reset = 1; O_ready = 0.
  - Stay for FAULT_HOLDOFF cycles, then go to IDLE with the retry counter cleared.
  - O_fault stays high until the next RUN entry, and clears on that entry cycle.
- Width rules:
  - Each timer width is $clog2 of its parameter plus 1.
  - Comparisons are unsigned.
  - A single shared timer is cleared on every state change.

Decomposition:
- Shared package dcm_seq_pkg:
  - state encodings (IDLE..FAULT, 3-bit);
  - O_relock_count width (8) and saturation value (255);
  - timer width function.
- Sub-module seq_timer: loadable terminal-count counter (clear, enable, terminal-count output). Reused for the RST, LOCK and HOLDOFF intervals and for the mismatch counter (second instance).

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, MAX_RETRIES=2, MISMATCH_CYCLES=8, FAULT_HOLDOFF=10.
1. Nominal low band: release reset; I_freq_set=1, I_freq_mode=0, I_freq_or=0; I_dcm_locked rises 5 cycles into WAIT_LOCK.
   → O_dcm_hf_sel=0; O_dcm_reset high exactly 4 cycles; O_ready=1; O_state=4.
2. High band with mode change in RUN:
   a. Lock with I_freq_mode=1. → O_dcm_hf_sel=1.
   b. Drive I_freq_mode=0 for 7 cycles, then 1 for one cycle. → Stays in RUN.
   c. Drive I_freq_mode=0 for 8 cycles. → IDLE, O_ready=0, O_relock_count=1, new measure latches hf_sel=0.
3. Lock timeout: never assert I_dcm_locked.
   → Two DCM_RST/WAIT_LOCK passes of 4+20 cycles each, then FAULT with O_fault=1 for 10 cycles, then IDLE.
   → O_fault stays 1 until the next RUN entry.
4. Out of range: I_freq_set=1 with I_freq_or=1 in MEASURE.
   → FAULT directly; O_dcm_hf_sel unchanged.
5. Lock loss and simultaneous events:
   - Drop I_dcm_locked in RUN on the same cycle as the 8th mismatch cycle. → DCM_RST, not IDLE; O_relock_count increments once.
   - Lock and timeout arriving on the same cycle. → RUN.
6. Reset mid-operation: assert I_reset during WAIT_LOCK.
   → Next cycle: O_state=0, O_dcm_reset=1, O_freq_reset=1, O_ready=0, O_fault=0, O_relock_count=0.
